// File: rtl/ram_fifo_pkg.sv
// Shared constants and helpers for the RAM-backed streaming FIFO controller.
// Threshold defaults follow the RAM address width chosen by the instantiating design.
package ram_fifo_pkg;

  localparam int DEFAULT_AW     = 8;
  localparam int DEFAULT_DW     = 32;
  localparam int DEFAULT_DEPTH  = 1 << DEFAULT_AW;
  localparam int AEMPTY_DEFAULT = 1;

  function automatic int depthOf(input int aw);
    return 1 << aw;
  endfunction

  // Occupancy spans 0 .. 2^AW+1 (RAM entries plus the output register).
  function automatic int occWidth(input int aw);
    return $clog2((1 << aw) + 2);
  endfunction

  function automatic int afullDefault(input int aw);
    return (1 << aw) - 2;
  endfunction

endpackage

// File: rtl/ram_fifo_outreg.sv
// One-entry registered output stage with valid/ready handshake and load enable.
// Flush drops the held word's valid bit but leaves the data bits untouched.
module ram_fifo_outreg
  import ram_fifo_pkg::*;
#(
  parameter int DW = DEFAULT_DW
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          flush_i,
  input  logic          load_i,
  input  logic [DW-1:0] loadData_i,
  input  logic          outReady_i,
  output logic          outValid_o,
  output logic [DW-1:0] outData_o
);

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;

  // A load wins over a release so back-to-back words stream at one per cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = loadData_i;
    end else if (valid_q && outReady_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign outValid_o = valid_q;
  assign outData_o  = data_q;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller wrapping a dual-port RAM: port A writes, port B reads into a
// registered output stage. Capacity is 2^AW RAM words plus the output register.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int AW        = DEFAULT_AW,
  parameter int DW        = DEFAULT_DW,
  parameter int AFULL_TH  = afullDefault(AW),
  parameter int AEMPTY_TH = AEMPTY_DEFAULT
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          flush,
  input  logic          inValid,
  output logic          inReady,
  input  logic [DW-1:0] inData,
  output logic          outValid,
  input  logic          outReady,
  output logic [DW-1:0] outData,
  output logic [AW:0]   occupancy,
  output logic          almostFull,
  output logic          almostEmpty,
  output logic          errConflict,
  output logic          ramAEn,
  output logic          ramAWrite,
  output logic [AW-1:0] ramAAddr,
  output logic [DW-1:0] ramAWriteData,
  output logic          ramBEn,
  output logic          ramBWrite,
  output logic [AW-1:0] ramBAddr,
  output logic [DW-1:0] ramBWriteData,
  input  logic [DW-1:0] ramBReadData,
  input  logic          ramConflict
);

  localparam int              DEPTH    = depthOf(AW);
  localparam int              OCC_W    = occWidth(AW);
  localparam logic [OCC_W-1:0] DEPTH_V  = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] AFULL_V  = OCC_W'(AFULL_TH);
  localparam logic [OCC_W-1:0] AEMPTY_V = OCC_W'(AEMPTY_TH);

  logic [AW-1:0]    wrPtr_q, wrPtr_d;
  logic [AW-1:0]    rdPtr_q, rdPtr_d;
  logic [OCC_W-1:0] ramCount_q, ramCount_d;
  logic             errConflict_q, errConflict_d;
  logic             push, fetch;
  logic [OCC_W-1:0] occ;

  // rstN gates inReady so nothing is advertised while the block is held in reset.
  assign inReady = rstN && (ramCount_q != DEPTH_V) && !flush;
  assign push    = inValid && inReady;
  assign fetch   = (ramCount_q != '0) && (!outValid || outReady) && !flush;

  always_comb begin
    wrPtr_d       = wrPtr_q;
    rdPtr_d       = rdPtr_q;
    ramCount_d    = ramCount_q;
    errConflict_d = errConflict_q;
    if (flush) begin
      wrPtr_d       = '0;
      rdPtr_d       = '0;
      ramCount_d    = '0;
      errConflict_d = 1'b0;
    end else begin
      if (push)        wrPtr_d = wrPtr_q + 1'b1;
      if (fetch)       rdPtr_d = rdPtr_q + 1'b1;
      if (push && !fetch)      ramCount_d = ramCount_q + OCC_W'(1);
      else if (fetch && !push) ramCount_d = ramCount_q - OCC_W'(1);
      if (ramConflict) errConflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr_q       <= '0;
      rdPtr_q       <= '0;
      ramCount_q    <= '0;
      errConflict_q <= 1'b0;
    end else begin
      wrPtr_q       <= wrPtr_d;
      rdPtr_q       <= rdPtr_d;
      ramCount_q    <= ramCount_d;
      errConflict_q <= errConflict_d;
    end
  end

  ram_fifo_outreg #(
    .DW(DW)
  ) u_outreg (
    .clk        (clk),
    .rstN       (rstN),
    .flush_i    (flush),
    .load_i     (fetch),
    .loadData_i (ramBReadData),
    .outReady_i (outReady),
    .outValid_o (outValid),
    .outData_o  (outData)
  );

  assign occ         = ramCount_q + {{(OCC_W-1){1'b0}}, outValid};
  assign occupancy   = occ;
  assign almostFull  = (occ >= AFULL_V);
  assign almostEmpty = (occ <= AEMPTY_V);
  assign errConflict = errConflict_q;

  assign ramAEn        = push;
  assign ramAWrite     = push;
  assign ramAAddr      = wrPtr_q;
  assign ramAWriteData = inData;
  assign ramBEn        = fetch;
  assign ramBWrite     = 1'b0;
  assign ramBAddr      = rdPtr_q;
  assign ramBWriteData = '0;

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Directed-vector and scoreboard bench for ram_fifo_ctrl with a small behavioural RAM.
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
module tb_ram_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int AFULL = 4;
  localparam int AEMPTY = 1;
  localparam int NWORDS = 1000;

  logic          clk = 1'b0;
  logic          rstN;
  logic          flush, inValid, outReady, conflictInj;
  logic [DW-1:0] inData;
  logic          inReady, outValid, almostFull, almostEmpty, errConflict;
  logic [DW-1:0] outData, ramAWriteData, ramBWriteData, ramBReadData;
  logic [AW:0]   occupancy;
  logic          ramAEn, ramAWrite, ramBEn, ramBWrite, ramConflict;
  logic [AW-1:0] ramAAddr, ramBAddr;
  logic [DW-1:0] mem [4];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic          ordy;
    logic          expInReady;
    logic          expOutValid;
    logic [DW-1:0] expOutData;
    logic [AW:0]   expOcc;
    logic          expRamAEn;
  } vec_t;

  vec_t vecs [26];

  always #5 clk = ~clk;

  ram_fifo_ctrl #(
    .AW(AW), .DW(DW), .AFULL_TH(AFULL), .AEMPTY_TH(AEMPTY)
  ) dut (
    .clk(clk), .rstN(rstN), .flush(flush),
    .inValid(inValid), .inReady(inReady), .inData(inData),
    .outValid(outValid), .outReady(outReady), .outData(outData),
    .occupancy(occupancy), .almostFull(almostFull), .almostEmpty(almostEmpty),
    .errConflict(errConflict),
    .ramAEn(ramAEn), .ramAWrite(ramAWrite), .ramAAddr(ramAAddr), .ramAWriteData(ramAWriteData),
    .ramBEn(ramBEn), .ramBWrite(ramBWrite), .ramBAddr(ramBAddr), .ramBWriteData(ramBWriteData),
    .ramBReadData(ramBReadData), .ramConflict(ramConflict)
  );

  // Behavioural stand-in for the dual-port RAM: registered write, combinational read.
  always @(posedge clk) begin
    if (ramAEn && ramAWrite) mem[ramAAddr] <= ramAWriteData;
  end
  assign ramBReadData = mem[ramBAddr];
  assign ramConflict  = conflictInj | (ramAEn && ramAWrite && ramBEn && (ramAAddr == ramBAddr));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    inValid  = iv;
    inData   = d;
    outReady = ordy;
    flush    = fl;
    @(negedge clk);
  endtask

  task automatic waitOutValid(input string name);
    int n = 0;
    while (outValid !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, " outValid"}, {31'd0, outValid}, 32'd1);
  endtask

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic ordy,
                              input logic eir, input logic eov, input logic [DW-1:0] eod,
                              input logic [AW:0] eocc, input logic eaen);
    vec_t v;
    v.iv = iv; v.d = d; v.ordy = ordy;
    v.expInReady = eir; v.expOutValid = eov; v.expOutData = eod;
    v.expOcc = eocc; v.expRamAEn = eaen;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] sb [$];
    int ramCnt, sent, recv, cyc;
    logic ovM, pushM, fetchM, popM;

    // Single word, fill to capacity, then streaming drain through pointer wrap.
    vecs[0]  = mk(1, 8'h11, 0, 1, 0, 8'h00, 0, 1);
    vecs[1]  = mk(0, 8'h00, 0, 1, 0, 8'h00, 1, 0);
    vecs[2]  = mk(0, 8'h00, 0, 1, 1, 8'h11, 1, 0);
    vecs[3]  = mk(0, 8'h00, 1, 1, 1, 8'h11, 1, 0);
    vecs[4]  = mk(0, 8'h00, 0, 1, 0, 8'h11, 0, 0);
    vecs[5]  = mk(1, 8'h01, 0, 1, 0, 8'h11, 0, 1);
    vecs[6]  = mk(1, 8'h02, 0, 1, 0, 8'h11, 1, 1);
    vecs[7]  = mk(1, 8'h03, 0, 1, 1, 8'h01, 2, 1);
    vecs[8]  = mk(1, 8'h04, 0, 1, 1, 8'h01, 3, 1);
    vecs[9]  = mk(1, 8'h05, 0, 1, 1, 8'h01, 4, 1);
    vecs[10] = mk(1, 8'h06, 0, 0, 1, 8'h01, 5, 0);
    vecs[11] = mk(1, 8'h06, 0, 0, 1, 8'h01, 5, 0);
    vecs[12] = mk(1, 8'h06, 1, 0, 1, 8'h01, 5, 0);
    vecs[13] = mk(1, 8'h06, 1, 1, 1, 8'h02, 4, 1);
    vecs[14] = mk(1, 8'h07, 1, 1, 1, 8'h03, 4, 1);
    vecs[15] = mk(1, 8'h08, 1, 1, 1, 8'h04, 4, 1);
    vecs[16] = mk(1, 8'h09, 1, 1, 1, 8'h05, 4, 1);
    vecs[17] = mk(1, 8'h0A, 1, 1, 1, 8'h06, 4, 1);
    vecs[18] = mk(1, 8'h0B, 1, 1, 1, 8'h07, 4, 1);
    vecs[19] = mk(1, 8'h0C, 1, 1, 1, 8'h08, 4, 1);
    vecs[20] = mk(1, 8'h0D, 1, 1, 1, 8'h09, 4, 1);
    vecs[21] = mk(0, 8'h00, 1, 1, 1, 8'h0A, 4, 0);
    vecs[22] = mk(0, 8'h00, 1, 1, 1, 8'h0B, 3, 0);
    vecs[23] = mk(0, 8'h00, 1, 1, 1, 8'h0C, 2, 0);
    vecs[24] = mk(0, 8'h00, 1, 1, 1, 8'h0D, 1, 0);
    vecs[25] = mk(0, 8'h00, 0, 1, 0, 8'h0D, 0, 0);

    rstN = 1'b0; flush = 1'b0; inValid = 1'b1; inData = 8'h00; outReady = 1'b0; conflictInj = 1'b0;
    #12;
    checkOutput("reset inReady", {31'd0, inReady}, 32'd0);
    checkOutput("reset outValid", {31'd0, outValid}, 32'd0);
    checkOutput("reset outData", {24'd0, outData}, 32'd0);
    checkOutput("reset occupancy", {29'd0, occupancy}, 32'd0);
    checkOutput("reset almostEmpty", {31'd0, almostEmpty}, 32'd1);
    checkOutput("reset almostFull", {31'd0, almostFull}, 32'd0);
    checkOutput("reset errConflict", {31'd0, errConflict}, 32'd0);
    inValid = 1'b0;
    @(posedge clk);
    #1 rstN = 1'b1;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].iv, vecs[i].d, vecs[i].ordy, 1'b0);
      checkOutput($sformatf("vec%0d inReady", i), {31'd0, inReady}, {31'd0, vecs[i].expInReady});
      checkOutput($sformatf("vec%0d outValid", i), {31'd0, outValid}, {31'd0, vecs[i].expOutValid});
      checkOutput($sformatf("vec%0d outData", i), {24'd0, outData}, {24'd0, vecs[i].expOutData});
      checkOutput($sformatf("vec%0d occupancy", i), {29'd0, occupancy}, {29'd0, vecs[i].expOcc});
      checkOutput($sformatf("vec%0d almostFull", i), {31'd0, almostFull},
                  {31'd0, (vecs[i].expOcc >= 3'(AFULL))});
      checkOutput($sformatf("vec%0d almostEmpty", i), {31'd0, almostEmpty},
                  {31'd0, (vecs[i].expOcc <= 3'(AEMPTY))});
      checkOutput($sformatf("vec%0d ramAEn", i), {31'd0, ramAEn}, {31'd0, vecs[i].expRamAEn});
      checkOutput($sformatf("vec%0d ramBWrite", i), {31'd0, ramBWrite}, 32'd0);
    end

    // Flush with three words held, plus sticky conflict flag cleared by flush.
    applyStimulus(1, 8'hC1, 0, 0);
    applyStimulus(1, 8'hC2, 0, 0);
    applyStimulus(1, 8'hC3, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("preflush occupancy", {29'd0, occupancy}, 32'd3);
    conflictInj = 1'b1;
    applyStimulus(0, 8'h00, 0, 0);
    conflictInj = 1'b0;
    checkOutput("conflict set", {31'd0, errConflict}, 32'd1);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("conflict sticky", {31'd0, errConflict}, 32'd1);
    applyStimulus(1, 8'h77, 1, 1);
    checkOutput("flush inReady", {31'd0, inReady}, 32'd0);
    checkOutput("flush ramAEn", {31'd0, ramAEn}, 32'd0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("postflush occupancy", {29'd0, occupancy}, 32'd0);
    checkOutput("postflush outValid", {31'd0, outValid}, 32'd0);
    checkOutput("postflush inReady", {31'd0, inReady}, 32'd1);
    checkOutput("postflush errConflict", {31'd0, errConflict}, 32'd0);
    applyStimulus(1, 8'hAA, 1, 0);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("AA latency", {31'd0, outValid}, 32'd0);
    waitOutValid("AA");
    checkOutput("AA first out", {24'd0, outData}, 32'hAA);

    // Asynchronous reset in the middle of a transfer.
    applyStimulus(1, 8'h31, 0, 0);
    applyStimulus(1, 8'h32, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    checkOutput("prereset outValid", {31'd0, outValid}, 32'd1);
    @(posedge clk);
    #2 rstN = 1'b0;
    #1;
    checkOutput("async outValid", {31'd0, outValid}, 32'd0);
    checkOutput("async occupancy", {29'd0, occupancy}, 32'd0);
    checkOutput("async inReady", {31'd0, inReady}, 32'd0);
    @(posedge clk);
    #1 rstN = 1'b1;
    applyStimulus(1, 8'h5A, 1, 0);
    applyStimulus(0, 8'h00, 1, 0);
    waitOutValid("after reset");
    checkOutput("after reset data", {24'd0, outData}, 32'h5A);
    checkOutput("after reset occupancy", {29'd0, occupancy}, 32'd1);
    applyStimulus(0, 8'h00, 1, 0);
    checkOutput("drained occupancy", {29'd0, occupancy}, 32'd0);

    // Random handshakes against an occupancy model and word scoreboard.
    ramCnt = 0; ovM = 1'b0; sent = 0; recv = 0; cyc = 0;
    while (recv < NWORDS && cyc < 20000) begin
      @(posedge clk);
      #1;
      inValid  = (sent < NWORDS) && ($urandom_range(0, 1) == 1);
      inData   = 8'($urandom_range(0, 255));
      outReady = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      pushM  = inValid && (ramCnt != 4);
      fetchM = (ramCnt != 0) && (!ovM || outReady);
      popM   = ovM && outReady;
      checkOutput("rand occupancy", {29'd0, occupancy}, 32'(ramCnt) + {31'd0, ovM});
      checkOutput("rand inReady", {31'd0, inReady}, {31'd0, (ramCnt != 4)});
      checkOutput("rand outValid", {31'd0, outValid}, {31'd0, ovM});
      if (popM) begin
        checkOutput("rand outData", {24'd0, outData}, {24'd0, sb[0]});
        void'(sb.pop_front());
        recv++;
      end
      if (pushM) begin
        sb.push_back(inData);
        sent++;
      end
      if (pushM && !fetchM) ramCnt++;
      else if (fetchM && !pushM) ramCnt--;
      if (fetchM) ovM = 1'b1;
      else if (popM) ovM = 1'b0;
      cyc++;
    end
    checkOutput("rand words received", 32'(recv), 32'(NWORDS));
    checkOutput("rand errConflict", {31'd0, errConflict}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
